conv_dp: RTL and testbench

- Convolution datapath: consumes the load/accumulate controls and DRAM read data produced by the convolution controller. Returns the partial sum to be written back to the output feature map region.
- Holds up to KNL_MAXNUM kernels of one input channel in a weight buffer, plus a 5x5 input window.
- Each MAC request computes one 25-term dot product for one output channel.
- The result is either the dot product alone or the dot product plus the psum read from DRAM. It is aligned to the controller's write strobe.

---
 rtl/conv_pkg.sv | 30 +++
 rtl/conv_dp_if.sv | 32 +++
 rtl/conv_mac_tree.sv | 63 ++++++
 rtl/conv_dp.sv | 85 ++++++++
 tb/tb_conv_dp.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath and its controller.
//   DATA_WIDTH  : word width of DRAM data and psums
//   KNL_*       : kernel geometry and kernel buffer depth
//   FRAC_BITS   : fractional bits of the signed fixed-point format
//   fx_mul()    : fixed-point multiply (full product, arithmetic shift, truncate)
package conv_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int KNL_WIDTH  = 5;
    localparam int KNL_HEIGHT = 5;
    localparam int KNL_SIZE   = KNL_WIDTH * KNL_HEIGHT;
    localparam int KNL_MAXNUM = 16;
    localparam int FRAC_BITS  = 16;

    // Full 2*DATA_WIDTH product, arithmetic shift by FRAC_BITS, keep low word.
    function automatic logic signed [DATA_WIDTH-1:0] fx_mul(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [2*DATA_WIDTH-1:0] a_x;
        logic signed [2*DATA_WIDTH-1:0] b_x;
        logic signed [2*DATA_WIDTH-1:0] p;
        a_x = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a});
        b_x = $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
        p   = a_x * b_x;
        p   = p >>> FRAC_BITS;
        return p[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/conv_dp_if.sv
// Controller <-> convolution datapath bus.
//   data_in     : DRAM read word (weight, ifmap pixel or psum)
//   en_ld_knl   : data_in is the next weight
//   en_ld_ifmap : data_in is the next ifmap pixel
//   disable_acc : ignore psum (first input channel), sampled in MAC stage 2
//   mac_valid   : start one dot product
//   knl_sel     : kernel index for the MAC (bit 4 unused)
//   data_out    : accumulated psum for write-back
//   out_valid   : data_out valid this cycle
interface conv_dp_if;
    import conv_pkg::*;

    logic [DATA_WIDTH-1:0] data_in;
    logic                  en_ld_knl;
    logic                  en_ld_ifmap;
    logic                  disable_acc;
    logic                  mac_valid;
    logic [4:0]            knl_sel;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  out_valid;

    modport master (
        output data_in, en_ld_knl, en_ld_ifmap, disable_acc, mac_valid, knl_sel,
        input  data_out, out_valid
    );

    modport slave (
        input  data_in, en_ld_knl, en_ld_ifmap, disable_acc, mac_valid, knl_sel,
        output data_out, out_valid
    );

endinterface

// File: rtl/conv_mac_tree.sv
// 25-term fixed-point dot product, two-stage pipeline.
//   clk, srstn    : clock, synchronous active-low reset (valid bits and output)
//   i_vld         : start a dot product this cycle
//   i_wts/i_win   : weights and window pixels, both in weight order
//   i_disable_acc : stage-2 control, drop the psum
//   i_psum        : stage-2 psum to accumulate
//   o_data/o_vld  : result and its valid, two cycles after i_vld
module conv_mac_tree
    import conv_pkg::*;
(
    input  logic                         clk,
    input  logic                         srstn,
    input  logic                         i_vld,
    input  logic signed [DATA_WIDTH-1:0] i_wts [KNL_SIZE],
    input  logic signed [DATA_WIDTH-1:0] i_win [KNL_SIZE],
    input  logic                         i_disable_acc,
    input  logic signed [DATA_WIDTH-1:0] i_psum,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_vld
);

    logic signed [DATA_WIDTH-1:0] r_prod_p1 [KNL_SIZE];
    logic                         r_vld_p1;
    logic signed [DATA_WIDTH-1:0] r_data_p2;
    logic                         r_vld_p2;
    logic signed [DATA_WIDTH-1:0] w_sum;

    // ---- stage 1: multipliers ----
    always_ff @(posedge clk) begin
        if (i_vld) begin
            for (int k = 0; k < KNL_SIZE; k++) begin
                r_prod_p1[k] <= fx_mul(i_wts[k], i_win[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) r_vld_p1 <= 1'b0;
        else        r_vld_p1 <= i_vld;
    end

    // ---- stage 2: adder tree plus psum, wraps modulo 2^DATA_WIDTH ----
    always_comb begin
        w_sum = i_disable_acc ? '0 : i_psum;
        for (int k = 0; k < KNL_SIZE; k++) begin
            w_sum = w_sum + r_prod_p1[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_data_p2 <= '0;
            r_vld_p2  <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) r_data_p2 <= w_sum;
        end
    end

    assign o_data = r_data_p2;
    assign o_vld  = r_vld_p2;

endmodule

// File: rtl/conv_dp.sv
// Convolution datapath: kernel weight buffer, 5x5 ifmap window and a
// two-stage MAC producing one output-channel psum per request.
//   clk   : clock
//   srstn : synchronous active-low reset (pointers, valids, data_out)
//   bus   : controller bus (slave side), see conv_dp_if
module conv_dp
    import conv_pkg::*;
(
    input  logic      clk,
    input  logic      srstn,
    conv_dp_if.slave  bus
);

    localparam logic [4:0] WT_LAST = 5'(KNL_SIZE - 1);

    logic signed [DATA_WIDTH-1:0] r_wts [KNL_MAXNUM][KNL_SIZE];
    logic signed [DATA_WIDTH-1:0] r_win [KNL_SIZE];
    logic [4:0]                   r_wt_ptr;
    logic [3:0]                   r_knl_ptr;

    logic signed [DATA_WIDTH-1:0] w_wts_sel [KNL_SIZE];
    logic signed [DATA_WIDTH-1:0] w_win_map [KNL_SIZE];
    logic signed [DATA_WIDTH-1:0] w_data_out;
    logic                         w_out_valid;
    logic                         w_unused_sel;

    // Only 16 kernels exist; the controller's top select bit is don't-care.
    assign w_unused_sel = bus.knl_sel[4];

    // Load pointers restart at kernel 0, weight 0 whenever a burst ends.
    always_ff @(posedge clk) begin
        if (!srstn || !bus.en_ld_knl) begin
            r_wt_ptr  <= '0;
            r_knl_ptr <= '0;
        end else if (r_wt_ptr == WT_LAST) begin
            r_wt_ptr  <= '0;
            r_knl_ptr <= r_knl_ptr + 4'd1;
        end else begin
            r_wt_ptr  <= r_wt_ptr + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.en_ld_knl) r_wts[r_knl_ptr][r_wt_ptr] <= $signed(bus.data_in);
    end

    // Window is column-major; a weight load in the same cycle blocks the shift.
    always_ff @(posedge clk) begin
        if (bus.en_ld_ifmap && !bus.en_ld_knl) begin
            for (int i = 0; i < KNL_SIZE - 1; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[KNL_SIZE-1] <= $signed(bus.data_in);
        end
    end

    // Present window in weight (row-major) order: win[dx*H+dy] -> k=dy*W+dx.
    always_comb begin
        for (int k = 0; k < KNL_SIZE; k++) begin
            w_wts_sel[k] = r_wts[bus.knl_sel[3:0]][k];
            w_win_map[k] = '0;
        end
        for (int dy = 0; dy < KNL_HEIGHT; dy++) begin
            for (int dx = 0; dx < KNL_WIDTH; dx++) begin
                w_win_map[dy*KNL_WIDTH+dx] = r_win[dx*KNL_HEIGHT+dy];
            end
        end
    end

    conv_mac_tree u_mac (
        .clk           (clk),
        .srstn         (srstn),
        .i_vld         (bus.mac_valid),
        .i_wts         (w_wts_sel),
        .i_win         (w_win_map),
        .i_disable_acc (bus.disable_acc),
        .i_psum        ($signed(bus.data_in)),
        .o_data        (w_data_out),
        .o_vld         (w_out_valid)
    );

    assign bus.data_out  = w_data_out;
    assign bus.out_valid = w_out_valid;

endmodule

// File: tb/tb_conv_dp.sv
// Directed bench for conv_dp: loads kernels/windows, issues MACs and
// compares against hand-computed fixed-point results.
module tb_conv_dp;
    import conv_pkg::*;

    localparam logic [31:0] ONE = 32'h0001_0000;

    logic clk;
    logic srstn;
    int   n_cmp;
    int   n_mis;

    logic [31:0] wbuf [16][25];
    logic [31:0] pix  [25];

    conv_dp_if bus ();

    conv_dp dut (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic clear_wbuf();
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < 25; i++) wbuf[k][i] = 32'h0;
    endtask

    task automatic clear_pix();
        for (int i = 0; i < 25; i++) pix[i] = 32'h0;
    endtask

    task automatic load_kernels(input int nk);
        for (int k = 0; k < nk; k++) begin
            for (int i = 0; i < 25; i++) begin
                bus.en_ld_knl = 1'b1;
                bus.data_in   = wbuf[k][i];
                @(negedge clk);
            end
        end
        bus.en_ld_knl = 1'b0;
        bus.data_in   = 32'h0;
        @(negedge clk);
    endtask

    task automatic load_win(input int n);
        for (int i = 0; i < n; i++) begin
            bus.en_ld_ifmap = 1'b1;
            bus.data_in     = pix[i];
            @(negedge clk);
        end
        bus.en_ld_ifmap = 1'b0;
        bus.data_in     = 32'h0;
        @(negedge clk);
    endtask

    task automatic mac_one(input string tag, input logic [4:0] sel, input logic dis,
                           input logic [31:0] psum, input logic [31:0] exp);
        bus.mac_valid = 1'b1;
        bus.knl_sel   = sel;
        @(negedge clk);
        bus.mac_valid   = 1'b0;
        bus.disable_acc = dis;
        bus.data_in     = psum;
        check({tag, "_early"}, {31'h0, bus.out_valid}, 32'h0);
        @(negedge clk);
        bus.data_in = 32'h0;
        check({tag, "_vld"}, {31'h0, bus.out_valid}, 32'h1);
        check(tag, bus.data_out, exp);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_mis = 0;
        srstn = 1'b0;
        bus.data_in = '0; bus.en_ld_knl = 1'b0; bus.en_ld_ifmap = 1'b0;
        bus.disable_acc = 1'b1; bus.mac_valid = 1'b0; bus.knl_sel = '0;
        repeat (3) @(negedge clk);
        check("rst_vld", {31'h0, bus.out_valid}, 32'h0);
        check("rst_data", bus.data_out, 32'h0);
        srstn = 1'b1;
        @(negedge clk);

        // All-ones: 25 * 1.0 * 1.0
        clear_wbuf();
        for (int i = 0; i < 25; i++) begin wbuf[0][i] = ONE; pix[i] = ONE; end
        load_kernels(1);
        load_win(25);
        mac_one("ones", 5'd0, 1'b1, 32'h0, 32'h0019_0000);
        mac_one("ones_acc", 5'd0, 1'b0, 32'h0005_0000, 32'h001E_0000);
        check("hold_vld", {31'h0, bus.out_valid}, 32'h0);
        check("hold_data", bus.data_out, 32'h001E_0000);

        // Kernel indexing, back-to-back; odd cycles set knl_sel[4] which must be ignored
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < 25; i++) wbuf[k][i] = 32'(k) << 16;
        load_kernels(16);
        bus.disable_acc = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c >= 2) begin
                check($sformatf("idx%0d_vld", c - 2), {31'h0, bus.out_valid}, 32'h1);
                check($sformatf("idx%0d", c - 2), bus.data_out, 32'(25 * (c - 2)) << 16);
            end
            if (c < 16) begin
                bus.mac_valid = 1'b1;
                bus.knl_sel   = {c[0], c[3:0]};
            end else begin
                bus.mac_valid = 1'b0;
                bus.knl_sel   = '0;
            end
            @(negedge clk);
        end
        check("idx_end_vld", {31'h0, bus.out_valid}, 32'h0);

        // Window slide: weight (dy=0,dx=4) only
        clear_wbuf();
        wbuf[0][4] = ONE;
        load_kernels(1);
        for (int dx = 0; dx < 5; dx++)
            for (int dy = 0; dy < 5; dy++) pix[dx*5+dy] = 32'(dx) << 16;
        load_win(25);
        mac_one("pre_slide", 5'd0, 1'b1, 32'h0, 32'h0004_0000);
        for (int i = 0; i < 5; i++) pix[i] = 32'h0005_0000;
        load_win(5);
        mac_one("post_slide", 5'd0, 1'b1, 32'h0, 32'h0005_0000);

        // Signed: -2.0 * 3.0
        clear_wbuf();
        wbuf[0][0] = 32'hFFFE_0000;
        load_kernels(1);
        clear_pix();
        pix[0] = 32'h0003_0000;
        load_win(25);
        mac_one("signed", 5'd0, 1'b1, 32'h0, 32'hFFFA_0000);

        // Wrap: 1.0 * 2.0 + 0x7FFF0000
        wbuf[0][0] = ONE;
        load_kernels(1);
        clear_pix();
        pix[0] = 32'h0002_0000;
        load_win(25);
        mac_one("wrap", 5'd0, 1'b0, 32'h7FFF_0000, 32'h8001_0000);

        // Load collision: first weight written with both enables high
        for (int i = 0; i < 25; i++) begin
            bus.en_ld_knl   = 1'b1;
            bus.en_ld_ifmap = (i == 0);
            bus.data_in     = (i == 0) ? 32'h0000_1234 : 32'h0;
            @(negedge clk);
        end
        bus.en_ld_knl = 1'b0; bus.en_ld_ifmap = 1'b0; bus.data_in = 32'h0;
        @(negedge clk);
        mac_one("collide", 5'd0, 1'b1, 32'h0, 32'h0000_2468);

        // Reset mid-MAC with a weight burst still active across reset
        for (int i = 0; i < 27; i++) begin
            bus.en_ld_knl = 1'b1;
            bus.data_in   = 32'h0;
            bus.mac_valid = (i == 26);
            bus.knl_sel   = 5'd0;
            @(negedge clk);
        end
        bus.mac_valid = 1'b0;
        srstn = 1'b0;
        @(negedge clk);
        check("rmid_vld0", {31'h0, bus.out_valid}, 32'h0);
        check("rmid_data0", bus.data_out, 32'h0);
        @(negedge clk);
        check("rmid_vld1", {31'h0, bus.out_valid}, 32'h0);
        check("rmid_data1", bus.data_out, 32'h0);
        srstn = 1'b1;
        for (int i = 0; i < 25; i++) begin
            bus.data_in = (i == 0) ? ONE : 32'h0;
            @(negedge clk);
            if (i < 2) begin
                check($sformatf("rmid_vld_after%0d", i), {31'h0, bus.out_valid}, 32'h0);
                check($sformatf("rmid_data_after%0d", i), bus.data_out, 32'h0);
            end
        end
        bus.en_ld_knl = 1'b0;
        bus.data_in   = 32'h0;
        @(negedge clk);
        clear_pix();
        pix[0] = 32'h0007_0000;
        load_win(25);
        mac_one("rst_ptr", 5'd0, 1'b1, 32'h0, 32'h0007_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
